// File: rtl/lut_selftest_sequencer.sv
// rtl/lut_selftest_sequencer.sv - exhaustive truth-table self-test sequencer for one N-input LUT
module lut_selftest_sequencer #(
  parameter int                       N_INPUTS      = 1,
  parameter logic [2**N_INPUTS-1:0]   INIT          = 2'b01,
  parameter int                       SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [N_INPUTS-1:0] lut_in,
  input  logic                lut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_fail,
  output logic                first_fail_valid
);

  localparam int              PATTERNS    = 2**N_INPUTS;
  localparam logic [N_INPUTS:0] ERR_MAX   = PATTERNS[N_INPUTS:0];
  localparam int              SETTLE_INIT = SETTLE_CYCLES - 1;
  localparam logic [7:0]      SETTLE_LOAD = SETTLE_INIT[7:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [N_INPUTS-1:0]   lut_in_d;
  logic                  busy_d, done_d, pass_d, ffv_d;
  logic [N_INPUTS:0]     err_d;
  logic [N_INPUTS-1:0]   ff_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      lut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      lut_in           <= lut_in_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      err_count        <= err_d;
      first_fail       <= ff_d;
      first_fail_valid <= ffv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lut_in_d = lut_in;
    busy_d   = busy;
    done_d   = done;
    pass_d   = pass;
    err_d    = err_count;
    ff_d     = first_fail;
    ffv_d    = first_fail_valid;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          ff_d     = '0;
          ffv_d    = 1'b0;
          lut_in_d = '0;
          cnt_d    = SETTLE_LOAD;
          busy_d   = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      CHECK: begin
        // lut_out is only looked at here, so an undriven output elsewhere never reaches status
        if (lut_out != INIT[lut_in]) begin
          if (err_count != ERR_MAX) err_d = err_count + 1'b1;
          if (!first_fail_valid) begin
            ff_d  = lut_in;
            ffv_d = 1'b1;
          end
        end
        if (&lut_in) begin
          state_d = DONE;
        end else begin
          lut_in_d = lut_in + 1'b1;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        done_d   = 1'b1;
        pass_d   = (err_count == '0);
        busy_d   = 1'b0;
        lut_in_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // partial error status survives an abort for debug
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      lut_in_d = '0;
    end
  end

endmodule
